// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// byte/word geometry of the incoming stream.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Little-endian byte-to-word assembler: lanes 0..2 are buffered, lane 3 completes
// the word and raises a one-cycle word_valid in the following cycle.
module prog_loader_word_packer
  import prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [LANE_W-1:0] lane,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [3*BYTE_W-1:0]      buf_q, buf_d;
  logic [WORD_W-1:0]        word_q, word_d;
  logic                     valid_q, valid_d;

  always_comb begin
    lane_d  = lane_q;
    buf_d   = buf_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear) begin
      lane_d = '0;
      buf_d  = '0;
    end else if (byte_en) begin
      case (lane_q)
        2'd0: buf_d[7:0]   = byte_in;
        2'd1: buf_d[15:8]  = byte_in;
        2'd2: buf_d[23:16] = byte_in;
        default: begin
          word_d  = {byte_in, buf_q};
          valid_d = 1'b1;
        end
      endcase
      lane_d = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_q  <= '0;
      buf_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign lane       = lane_q;
  assign word_valid = valid_q;
  assign word_data  = word_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses LEN_LO, LEN_HI, 4*N data bytes and an XOR checksum byte,
// writes words to consecutive RAM addresses, and holds the core in reset until verified.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_data is ignored otherwise.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] BASE_ADDR    = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    mem_wEn,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [31:0]             mem_write_data,
  output logic                    cpu_reset,
  output logic                    done,
  output logic                    error,
  output logic [ADDRESS_BITS-1:0] words_written,
  output state_t                  dbg_state
);

  localparam logic [ADDRESS_BITS-1:0] ADDR_ONE = 1;

  state_t                  state_q, state_d;
  logic [15:0]             length_q, length_d;
  logic [15:0]             word_cnt_q, word_cnt_d;
  logic [7:0]              checksum_q, checksum_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [ADDRESS_BITS-1:0] words_q, words_d;

  logic              accept;
  logic              packer_clear;
  logic              byte_en;
  logic [LANE_W-1:0] lane;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;

  assign in_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CHECK);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    length_d     = length_q;
    word_cnt_d   = word_cnt_q;
    checksum_d   = checksum_q;
    addr_d       = addr_q;
    words_d      = words_q;
    packer_clear = 1'b0;
    byte_en      = 1'b0;

    // The strobe cycle presents the current address; it advances right after.
    if (word_valid) begin
      addr_d  = addr_q + ADDR_ONE;
      words_d = words_q + ADDR_ONE;
    end

    case (state_q)
      ST_LEN_LO: if (accept) begin
        length_d[7:0] = in_data;
        state_d       = ST_LEN_HI;
      end
      ST_LEN_HI: if (accept) begin
        length_d[15:8] = in_data;
        state_d        = ({in_data, length_q[7:0]} != 16'd0) ? ST_DATA : ST_CHECK;
      end
      ST_DATA: begin
        byte_en = accept;
        if (accept) begin
          checksum_d = checksum_q ^ in_data;
          if (lane == 2'd3) begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == length_q) state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: if (accept) begin
        state_d = (in_data == checksum_q) ? ST_DONE : ST_ERROR;
      end
      ST_IDLE, ST_DONE, ST_ERROR: if (start) begin
        state_d      = ST_LEN_LO;
        length_d     = '0;
        word_cnt_d   = '0;
        checksum_d   = '0;
        addr_d       = BASE_ADDR;
        words_d      = '0;
        packer_clear = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      length_q   <= '0;
      word_cnt_q <= '0;
      checksum_q <= '0;
      addr_q     <= BASE_ADDR;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      word_cnt_q <= word_cnt_d;
      checksum_q <= checksum_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
    end
  end

  prog_loader_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (packer_clear),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .lane       (lane),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  assign mem_wEn        = word_valid;
  assign mem_write_data = word_data;
  assign mem_address    = addr_q;
  assign words_written  = words_q;
  assign done           = (state_q == ST_DONE);
  assign error          = (state_q == ST_ERROR);
  assign cpu_reset      = (state_q != ST_DONE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one loader at BASE_ADDR 0 and one at 0xFFFF
// receive the same streams so address wrap is observed alongside every load.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready_a, wen_a, cpu_a, done_a, err_a;
  logic [15:0] addr_a, ww_a;
  logic [31:0] data_a;
  state_t      dbg_a;

  logic        in_ready_w, wen_w, cpu_w, done_w, err_w;
  logic [15:0] addr_w, ww_w;
  logic [31:0] data_w;
  state_t      dbg_w;

  logic [47:0] act_a[$], act_w[$], exp_q[$], exp_w[$];
  logic [7:0]  strm[16];
  int          strm_len;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  prog_loader #(.ADDRESS_BITS(16), .BASE_ADDR(16'h0000)) dut_a (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .mem_wEn(wen_a), .mem_address(addr_a), .mem_write_data(data_a),
    .cpu_reset(cpu_a), .done(done_a), .error(err_a), .words_written(ww_a), .dbg_state(dbg_a)
  );

  prog_loader #(.ADDRESS_BITS(16), .BASE_ADDR(16'hFFFF)) dut_w (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w), .mem_wEn(wen_w), .mem_address(addr_w), .mem_write_data(data_w),
    .cpu_reset(cpu_w), .done(done_w), .error(err_w), .words_written(ww_w), .dbg_state(dbg_w)
  );

  always @(negedge clock) begin
    if (wen_a) act_a.push_back({addr_a, data_a});
    if (wen_w) act_w.push_back({addr_w, data_w});
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 48'(in_ready_a), 48'd0);
    check({tag, "_wen"},      48'(wen_a),      48'd0);
    check({tag, "_addr_a"},   48'(addr_a),     48'h0000);
    check({tag, "_addr_w"},   48'(addr_w),     48'hFFFF);
    check({tag, "_wdata"},    48'(data_a),     48'd0);
    check({tag, "_cpu_rst"},  48'(cpu_a),      48'd1);
    check({tag, "_done"},     48'(done_a),     48'd0);
    check({tag, "_error"},    48'(err_a),      48'd0);
    check({tag, "_ww"},       48'(ww_a),       48'd0);
    check({tag, "_state"},    48'(dbg_a),      48'(ST_IDLE));
    check({tag, "_wen_w"},    48'(wen_w),      48'd0);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready_a && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready_a) check("in_ready_timeout", 48'(in_ready_a), 48'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_stream(input bit stall);
    for (int i = 0; i < strm_len; i++)
      send_byte(strm[i], stall ? int'($urandom_range(1, 5)) : 0);
    @(negedge clock);
  endtask

  task automatic fill_nominal(input logic [7:0] csum);
    strm[0] = 8'h02; strm[1] = 8'h00;
    strm[2] = 8'h78; strm[3] = 8'h56; strm[4] = 8'h34; strm[5] = 8'h12;
    strm[6] = 8'hEF; strm[7] = 8'hBE; strm[8] = 8'hAD; strm[9] = 8'hDE;
    strm[10] = csum;
    strm_len = 11;
    exp_q.push_back({16'h0000, 32'h12345678});
    exp_q.push_back({16'h0001, 32'hDEADBEEF});
    exp_w.push_back({16'hFFFF, 32'h12345678});
    exp_w.push_back({16'h0000, 32'hDEADBEEF});
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr_a"}, 48'(act_a.size()), 48'(exp_q.size()));
    check({tag, "_nwr_w"}, 48'(act_w.size()), 48'(exp_w.size()));
    for (int i = 0; i < act_a.size() && i < exp_q.size(); i++)
      check($sformatf("%s_wr_a%0d", tag, i), act_a[i], exp_q[i]);
    for (int i = 0; i < act_w.size() && i < exp_w.size(); i++)
      check($sformatf("%s_wr_w%0d", tag, i), act_w[i], exp_w[i]);
    act_a.delete(); act_w.delete(); exp_q.delete(); exp_w.delete();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic c, input logic [15:0] ww);
    check({tag, "_done"},     48'(done_a),     48'(d));
    check({tag, "_error"},    48'(err_a),      48'(e));
    check({tag, "_cpu_rst"},  48'(cpu_a),      48'(c));
    check({tag, "_ww"},       48'(ww_a),       48'(ww));
    check({tag, "_in_ready"}, 48'(in_ready_a), 48'd0);
    check({tag, "_done_w"},   48'(done_w),     48'(d));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #3;
    check_reset_vals("por");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_in_ready", 48'(in_ready_a), 48'd0);

    // Nominal load
    do_start();
    check("start_state", 48'(dbg_a), 48'(ST_LEN_LO));
    fill_nominal(8'h2A);
    send_stream(1'b0);
    check_writes("nom");
    check_status("nom", 1'b1, 1'b0, 1'b0, 16'd2);
    check("nom_addr_a", 48'(addr_a), 48'h0002);
    check("nom_addr_w", 48'(addr_w), 48'h0001);

    // Bad checksum, then a good reload
    do_start();
    check("restart_ww_clear", 48'(ww_a), 48'd0);
    check("restart_cpu_rst", 48'(cpu_a), 48'd1);
    fill_nominal(8'h00);
    send_stream(1'b0);
    check_writes("bad");
    check_status("bad", 1'b0, 1'b1, 1'b1, 16'd2);
    do_start();
    check("err_restart_clear", 48'(err_a), 48'd0);
    fill_nominal(8'h2A);
    send_stream(1'b0);
    check_writes("reload");
    check_status("reload", 1'b1, 1'b0, 1'b0, 16'd2);

    // Empty image
    do_start();
    strm[0] = 8'h00; strm[1] = 8'h00; strm[2] = 8'h00; strm_len = 3;
    send_stream(1'b0);
    check_writes("empty");
    check_status("empty", 1'b1, 1'b0, 1'b0, 16'd0);

    // Handshake stalls
    do_start();
    fill_nominal(8'h2A);
    send_stream(1'b1);
    check_writes("stall");
    check_status("stall", 1'b1, 1'b0, 1'b0, 16'd2);

    // Asynchronous reset in the middle of the first word
    do_start();
    strm[0] = 8'h01; strm[1] = 8'h00; strm[2] = 8'h78; strm[3] = 8'h56; strm_len = 4;
    for (int i = 0; i < strm_len; i++) send_byte(strm[i], 0);
    check("mid_state", 48'(dbg_a), 48'(ST_DATA));
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_writes("midrst");
    do_start();
    fill_nominal(8'h2A);
    send_stream(1'b0);
    check_writes("post_rst");
    check_status("post_rst", 1'b1, 1'b0, 1'b0, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 48'd0, 48'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "FAIL global_timeout");
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program loader for the single-cycle core. It is the writer side of the instruction/data RAM, which the core only reads at run time.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive RAM word addresses.
- Holds the core in reset until the image is loaded and its checksum verifies.
- Sits beside the main memory; its write port is muxed onto the RAM write port while cpu_reset is high.

Parameters:
- ADDRESS_BITS, 16: width of mem_address and words_written.
- BASE_ADDR, 0: word address of the first word written; width ADDRESS_BITS.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data; a byte transfers when in_valid and in_ready are both high at a rising edge.
- mem_wEn  output  1  one-cycle RAM write strobe.
- mem_address  output  ADDRESS_BITS  RAM word address.
- mem_write_data  output  32  RAM write data.
- cpu_reset  output  1  reset to the core; high while a load is pending, in progress or failed.
- done  output  1  load completed and checksum matched.
- error  output  1  checksum mismatch.
- words_written  output  ADDRESS_BITS  count of words written in the current load.

Behaviour:
- Reset values: state IDLE, in_ready 0, mem_wEn 0, mem_address BASE_ADDR, mem_write_data 0, cpu_reset 1, done 0, error 0, words_written 0, checksum 0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, then one checksum byte. The checksum is the XOR of all data bytes; the length bytes are excluded.

States:
- IDLE: in_ready 0. start -> LEN_LO; clear done, error, words_written and checksum; cpu_reset 1.
- LEN_LO: in_ready 1. Accepted byte -> length[7:0]; go to LEN_HI.
- LEN_HI: in_ready 1. Accepted byte -> length[15:8]. Go to DATA if length != 0, else CHECK.
- DATA: in_ready 1. Each accepted byte is XORed into the checksum and shifted into the word buffer at byte lane k (0..3). The first byte goes to bits [7:0].
  - On acceptance of lane 3: in the next cycle mem_wEn = 1, mem_write_data = the assembled word, mem_address = current address.
  - In the cycle after that, the address and words_written increment.
  - After the N-th word's lane 3 is accepted, go to CHECK.
- CHECK: in_ready 1. Accepted byte equal to the checksum -> DONE; otherwise -> ERROR.
- DONE: done 1, cpu_reset 0, in_ready 0. start -> restart as from IDLE.
- ERROR: error 1, cpu_reset 1, in_ready 0. start -> restart as from IDLE.

Timing and width rules:
- No RAM backpressure. A write strobe may overlap acceptance of the next word's lane 0, and the final write strobe may occur in the first cycle of CHECK.
- mem_wEn is never high outside the cycle after a lane-3 acceptance.
- mem_address wraps modulo 2^ADDRESS_BITS. No error is raised on wrap.
- N counts words, not bytes. N = 65535 is legal.
- in_valid gaps of any length stall progress without corrupting state. in_data is ignored when the transfer condition is false.
- start during LEN_LO, LEN_HI, DATA or CHECK is ignored.
- Asynchronous reset mid-load: immediately return all outputs to their reset values and discard any partial word. No write strobe issues.

Decomposition:
- Shared package: state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR), BYTES_PER_WORD = 4, byte-lane index width = 2.
- Sub-module word_packer: byte-lane shift register plus lane counter. It emits a word_valid pulse and the 32-bit word; the FSM owns length, address and checksum.

Test Plan:
- Nominal load: start; bytes 02 00 78 56 34 12 EF BE AD DE 2A -> writes 0x12345678 at BASE_ADDR and 0xDEADBEEF at BASE_ADDR+1, each with a one-cycle mem_wEn. Then done=1, cpu_reset=0, words_written=2.
- Bad checksum: same stream with final byte 0x00 -> both writes still occur. error=1, done=0, cpu_reset stays 1. A later start with the good stream reaches done=1.
- Empty image: start; bytes 00 00 00 -> no mem_wEn, done=1, cpu_reset=0, words_written=0.
- Handshake stalls: nominal stream with in_valid deasserted for 1-5 random cycles between bytes -> identical writes and final state as the nominal load. in_ready is 0 in IDLE/DONE/ERROR.
- Reset mid-word: assert reset after bytes 01 00 78 56 -> outputs return to reset values at once and no mem_wEn. A subsequent nominal load succeeds.
- Address wrap: BASE_ADDR=16'hFFFF, nominal stream -> writes at address 0xFFFF then 0x0000, done=1.
